sha_digest_serializer: RTL and testbench

- Downstream neighbour of the SHA-256 top level.
- Captures the 256-bit hash digest when the core signals completion and streams it out as bytes over a valid/ready handshake, most significant byte first.
- Feeds a byte-wide sink (UART TX, FIFO, host bridge) and decouples the core from sink back-pressure.

---
 rtl/sha_digest_serializer.sv | 85 ++++++++
 tb/tb_sha_digest_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sha_digest_serializer.sv
// Captures a hash digest on digest_valid and streams it MSB-first as bytes over valid/ready.
// Build option DIGEST_HEX_ASCII_EN emits each byte as two lowercase ASCII hex characters.
module sha_digest_serializer #(
  parameter  int DIGEST_W = 256,
  localparam int NBYTES   = DIGEST_W / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                digest_valid,
  input  logic [DIGEST_W-1:0] digest_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic                busy,
  output logic                overrun
);

`ifdef DIGEST_HEX_ASCII_EN
  localparam int BEATS = 2 * NBYTES;
`else
  localparam int BEATS = NBYTES;
`endif
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]          state;
  logic [DIGEST_W-1:0] shreg;
  logic [CNT_W-1:0]    cnt;
  logic                send, xfer, last, load, shift_en;
  logic [7:0]          top;

  assign send = (state == SEND);
  assign top  = shreg[DIGEST_W-1 -: 8];
  assign last = send && (cnt == CNT_W'(BEATS - 1));
  assign xfer = send && out_ready;
  // A new digest is accepted when idle or on the very cycle the final beat leaves.
  assign load = digest_valid && (!send || (xfer && last));

`ifdef DIGEST_HEX_ASCII_EN
  logic [3:0] nib;
  logic [7:0] hex_chr;
  assign nib      = cnt[0] ? top[3:0] : top[7:4];
  assign hex_chr  = (nib < 4'd10) ? {4'h3, nib} : (8'h57 + {4'h0, nib});
  assign out_data = send ? hex_chr : 8'h00;
  // Byte advances only once its low-nibble character has gone out.
  assign shift_en = cnt[0];
`else
  assign out_data = send ? top : 8'h00;
  assign shift_en = 1'b1;
`endif

  assign out_valid = send;
  assign busy      = send;
  assign out_last  = last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (digest_valid && send && !(xfer && last))
        overrun <= 1'b1;
      if (load) begin
        state <= SEND;
        shreg <= digest_in;
        cnt   <= '0;
      end else if (xfer) begin
        if (shift_en)
          shreg <= {shreg[DIGEST_W-9:0], 8'h00};
        if (last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha_digest_serializer.sv
// Directed bench for sha_digest_serializer: streaming, back-pressure, overrun, back-to-back, async reset.
module tb_sha_digest_serializer;

  localparam int DW  = 256;
  localparam int NB  = DW / 8;
`ifdef DIGEST_HEX_ASCII_EN
  localparam int NBT = 2 * NB;
`else
  localparam int NBT = NB;
`endif

  localparam logic [DW-1:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [DW-1:0] D11 = {32{8'h11}};
  localparam logic [DW-1:0] D22 = {32{8'h22}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          digest_valid = 1'b0;
  logic [DW-1:0] digest_in = '0;
  logic          out_valid, out_ready, out_last, busy, overrun;
  logic [7:0]    out_data;

  int tests = 0;
  int fails = 0;

  sha_digest_serializer #(.DIGEST_W(DW)) dut (
    .clk(clk), .rst(rst), .digest_valid(digest_valid), .digest_in(digest_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_beat(input logic [DW-1:0] d, input int i);
    logic [7:0] b;
    logic [3:0] n;
`ifdef DIGEST_HEX_ASCII_EN
    b = d[DW-1-8*(i/2) -: 8];
    n = (i % 2 == 1) ? b[3:0] : b[7:4];
    return (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
`else
    b = d[DW-1-8*i -: 8];
    n = 4'h0;
    return b ^ {n, n};
`endif
  endfunction

  // Called at a negedge where beat `from` is presented; ends at the negedge after the last transfer.
  task automatic beats(input logic [DW-1:0] d, input int from, input int inj_at, input logic [DW-1:0] inj);
    for (int i = from; i < NBT; i++) begin
      out_ready = 1'b1;
      check("beat_valid", 64'(out_valid), 64'd1);
      check("beat_data",  64'(out_data),  64'(exp_beat(d, i)));
      check("beat_last",  64'(out_last),  64'(i == NBT - 1));
      if (i == inj_at) begin
        digest_valid = 1'b1;
        digest_in    = inj;
      end
      @(negedge clk);
      digest_valid = 1'b0;
      digest_in    = '1;
    end
  endtask

  task automatic load(input logic [DW-1:0] d);
    digest_valid = 1'b1;
    digest_in    = d;
    @(negedge clk);
    digest_valid = 1'b0;
    digest_in    = '1;
  endtask

  initial begin
    int cyc, b, stalls;
    logic [7:0] first0, first1, lastb;
    out_ready = 1'b1;
`ifdef DIGEST_HEX_ASCII_EN
    first0 = 8'h62; first1 = 8'h61; lastb = 8'h64;
`else
    first0 = 8'hba; first1 = 8'h78; lastb = 8'had;
`endif

    // reset state
    @(negedge clk);
    check("rst_valid",   64'(out_valid), 64'd0);
    check("rst_last",    64'(out_last),  64'd0);
    check("rst_busy",    64'(busy),      64'd0);
    check("rst_overrun", 64'(overrun),   64'd0);
    check("rst_data",    64'(out_data),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready_ignored", 64'(out_valid), 64'd0);

    // binary/hex stream with out_ready=1
    load(ABC);
    check("lat1_valid", 64'(out_valid), 64'd1);
    check("lat1_busy",  64'(busy),      64'd1);
    check("first_byte", 64'(out_data),  64'(first0));
    @(negedge clk);
    check("second_byte", 64'(out_data), 64'(first1));
    beats(ABC, 1, -1, '0);
    check("s1_idle_valid", 64'(out_valid), 64'd0);
    check("s1_idle_busy",  64'(busy),      64'd0);

    // back-pressure: ready high every third cycle
    load(ABC);
    cyc = 0; b = 0; stalls = 0;
    while (b < NBT && cyc < 1000) begin
      out_ready = (cyc % 3 == 0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data",  64'(out_data),  64'(exp_beat(ABC, b)));
      check("bp_last",  64'(out_last),  64'(b == NBT - 1));
      if (out_ready) b++; else stalls++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp_done",   64'(b),      64'(NBT));
    check("bp_cycles", 64'(cyc),    64'(3 * NBT - 2));
    check("bp_stalls", 64'(stalls), 64'(2 * NBT - 2));
    check("bp_idle",   64'(out_valid), 64'd0);

    // back-to-back: new digest on the final handshake
    load(ABC);
    beats(ABC, 0, NBT - 1, D22);
    check("b2b_valid",   64'(out_valid), 64'd1);
    check("b2b_data",    64'(out_data),  64'(exp_beat(D22, 0)));
    check("b2b_overrun", 64'(overrun),   64'd0);
    beats(D22, 0, -1, '0);
    check("b2b_idle", 64'(out_valid), 64'd0);

    // overrun: digest dropped at beat 10
    load(ABC);
    beats(ABC, 0, 9, D11);
    check("ovr_set",  64'(overrun),   64'd1);
    check("ovr_idle", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("ovr_sticky",   64'(overrun),   64'd1);
    check("ovr_no_extra", 64'(out_valid), 64'd0);
    check("last_const",   64'(exp_beat(ABC, NBT - 1)), 64'(lastb));

    // asynchronous reset mid-transfer at beat 5
    load(ABC);
    repeat (4) @(negedge clk);
    check("ar_pre_data", 64'(out_data), 64'(exp_beat(ABC, 4)));
    #2 rst = 1'b1;
    #1;
    check("ar_valid",   64'(out_valid), 64'd0);
    check("ar_last",    64'(out_last),  64'd0);
    check("ar_busy",    64'(busy),      64'd0);
    check("ar_overrun", 64'(overrun),   64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ar_quiet", 64'(out_valid), 64'd0);
    end
    load(ABC);
    beats(ABC, 0, -1, '0);
    check("ar_end_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
